// File: rtl/cwc_capture_ctrl_if.sv
// cwc_capture_ctrl_if -- bundle of the capture-control request lines and the
// trace-RAM write port / status lines of cwc_capture_ctrl.
//   master : the capture controller (drives the trace RAM port and status)
//   slave  : the JTAG/trigger side (drives arm/abort/sample_en/trig_hit)
interface cwc_capture_ctrl_if #(
    parameter int ADDR_W = 16
) ();
    // Capture requests and per-cycle qualifiers
    logic              arm;
    logic              abort;
    logic              sample_en;
    logic              trig_hit;

    // Trace RAM write port
    logic              wt_ce;
    logic              wt_en;
    logic [ADDR_W-1:0] wt_addr;

    // Status for the JTAG status register
    logic [ADDR_W-1:0] trig_addr;
    logic              busy;
    logic              triggered;
    logic              done;
    logic              wrapped;

    modport master (
        input  arm, abort, sample_en, trig_hit,
        output wt_ce, wt_en, wt_addr, trig_addr, busy, triggered, done, wrapped
    );

    modport slave (
        output arm, abort, sample_en, trig_hit,
        input  wt_ce, wt_en, wt_addr, trig_addr, busy, triggered, done, wrapped
    );
endinterface

// File: rtl/cwc_capture_ctrl.sv
// cwc_capture_ctrl -- trace capture controller for a circular trace RAM.
// After an arm request the controller writes qualified samples into the RAM
// (PRE), latches the address of the first qualified trigger sample, writes
// STOP_LEN samples in total from the trigger onward (POST) and then parks in
// DONE with the capture frozen until the next arm or an abort.
//
// Optional feature: define CWC_TRIG_HOLDOFF_EN to ignore triggers until
// DEPTH-STOP_LEN samples have been written since arm, which guarantees a full
// pre-trigger window in the RAM.  Without the macro a trigger is accepted from
// the first PRE cycle and no holdoff counter is built.
module cwc_capture_ctrl #(
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 8192,
    parameter int STOP_LEN = 5461
) (
    input  logic                  trig_clk,
    input  logic                  jrstn,
    cwc_capture_ctrl_if.master    bus
);

    // Counter wide enough to hold any value 0..DEPTH
    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  POST_LOAD = CNT_W'(STOP_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
`ifdef CWC_TRIG_HOLDOFF_EN
    localparam logic [CNT_W-1:0]  HOLD_LEN  = CNT_W'(DEPTH - STOP_LEN);
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_POST = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_trig_addr;
    // Number of post-trigger writes still owed after the trigger sample
    logic [CNT_W-1:0]  r_post_cnt;
    logic              r_wt_ce;
    logic              r_busy;
    logic              r_triggered;
    logic              r_done;
    logic              r_wrapped;
`ifdef CWC_TRIG_HOLDOFF_EN
    // Samples written since arm, saturating at HOLD_LEN
    logic [CNT_W-1:0]  r_hold_cnt;
`endif

    logic              w_write;
    logic              w_ptr_wraps;
    logic [ADDR_W-1:0] w_ptr_next;
    logic              w_trig_ok;

    // Circular increment of the write pointer over 0..DEPTH-1
    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        if (p == LAST_ADDR) begin
            ptr_inc = {ADDR_W{1'b0}};
        end else begin
            ptr_inc = p + ADDR_W'(1);
        end
    endfunction

    // A write happens in a capturing state on a qualified sample; abort kills it
    assign w_write     = r_wt_ce & bus.sample_en & ~bus.abort;
    assign w_ptr_wraps = (r_ptr == LAST_ADDR);
    assign w_ptr_next  = ptr_inc(r_ptr);

`ifdef CWC_TRIG_HOLDOFF_EN
    assign w_trig_ok   = (r_hold_cnt == HOLD_LEN);
`else
    assign w_trig_ok   = 1'b1;
`endif

    // Capture FSM: state, write pointer, trigger latch, post counter and status
    always_ff @(posedge trig_clk or negedge jrstn) begin
        if (!jrstn) begin
            r_state     <= ST_IDLE;
            r_ptr       <= {ADDR_W{1'b0}};
            r_trig_addr <= {ADDR_W{1'b0}};
            r_post_cnt  <= CNT_ZERO;
            r_wt_ce     <= 1'b0;
            r_busy      <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_wrapped   <= 1'b0;
`ifdef CWC_TRIG_HOLDOFF_EN
            r_hold_cnt  <= CNT_ZERO;
`endif
        end else if (bus.abort) begin
            // Abort wins over arm and trigger; the pointer is left where it is
            r_state     <= ST_IDLE;
            r_trig_addr <= {ADDR_W{1'b0}};
            r_post_cnt  <= CNT_ZERO;
            r_wt_ce     <= 1'b0;
            r_busy      <= 1'b0;
            r_triggered <= 1'b0;
            r_done      <= 1'b0;
            r_wrapped   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.arm) begin
                        r_state     <= ST_PRE;
                        r_ptr       <= {ADDR_W{1'b0}};
                        r_trig_addr <= {ADDR_W{1'b0}};
                        r_post_cnt  <= CNT_ZERO;
                        r_wt_ce     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_triggered <= 1'b0;
                        r_done      <= 1'b0;
                        r_wrapped   <= 1'b0;
`ifdef CWC_TRIG_HOLDOFF_EN
                        r_hold_cnt  <= CNT_ZERO;
`endif
                    end
                end

                ST_PRE: begin
                    if (w_write) begin
                        r_ptr <= w_ptr_next;
                        if (w_ptr_wraps) begin
                            r_wrapped <= 1'b1;
                        end
`ifdef CWC_TRIG_HOLDOFF_EN
                        if (r_hold_cnt != HOLD_LEN) begin
                            r_hold_cnt <= r_hold_cnt + CNT_ONE;
                        end
`endif
                        // The trigger sample itself is written at r_ptr
                        if (bus.trig_hit && w_trig_ok) begin
                            r_trig_addr <= r_ptr;
                            r_triggered <= 1'b1;
                            if (STOP_LEN == 1) begin
                                r_state    <= ST_DONE;
                                r_post_cnt <= CNT_ZERO;
                                r_wt_ce    <= 1'b0;
                                r_busy     <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_state    <= ST_POST;
                                r_post_cnt <= POST_LOAD;
                            end
                        end
                    end
                end

                ST_POST: begin
                    // Trigger hits are ignored here; only qualified samples count
                    if (w_write) begin
                        r_ptr <= w_ptr_next;
                        if (w_ptr_wraps) begin
                            r_wrapped <= 1'b1;
                        end
                        if (r_post_cnt <= CNT_ONE) begin
                            r_state    <= ST_DONE;
                            r_post_cnt <= CNT_ZERO;
                            r_wt_ce    <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_post_cnt <= r_post_cnt - CNT_ONE;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_wt_ce <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wt_ce     = r_wt_ce;
    assign bus.wt_en     = w_write;
    assign bus.wt_addr   = r_ptr;
    assign bus.trig_addr = r_trig_addr;
    assign bus.busy      = r_busy;
    assign bus.triggered = r_triggered;
    assign bus.done      = r_done;
    assign bus.wrapped   = r_wrapped;

endmodule

// File: tb/tb_cwc_capture_ctrl.sv
// Self-checking bench for cwc_capture_ctrl (DEPTH=16, STOP_LEN=5).
// A behavioural model tracks the capture as "writes since arm" and derives
// pointer, wrap and trigger information from that count.
module tb_cwc_capture_ctrl;
    localparam int AW = 5;
    localparam int D  = 16;
    localparam int SL = 5;

    logic clk   = 1'b0;
    logic jrstn = 1'b0;

    cwc_capture_ctrl_if #(.ADDR_W(AW)) bus ();

    cwc_capture_ctrl #(.ADDR_W(AW), .DEPTH(D), .STOP_LEN(SL)) u_dut (
        .trig_clk (clk),
        .jrstn    (jrstn),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_PRE, M_POST, M_DONE} mph_t;

    mph_t m_ph;
    int   m_nwr;      // samples written since the last arm
    int   m_taddr;
    bit   m_trig, m_done, m_wrap;
    int   m_left;     // post-trigger samples still to write

    int errs = 0, checks = 0;
    int wr_pulses, last_wr_addr, post_writes;
    logic last_wt_en;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ph = M_IDLE; m_nwr = 0; m_taddr = 0;
        m_trig = 0; m_done = 0; m_wrap = 0; m_left = 0;
    endfunction

    function automatic bit model_capturing();
        return (m_ph == M_PRE) || (m_ph == M_POST);
    endfunction

    function automatic void model_step(bit a, bit ab, bit se, bit th);
        bit w;
        int addr;
        bit hold_ok;
        w = model_capturing() && se && !ab;
        if (ab) begin
            m_ph = M_IDLE; m_trig = 0; m_done = 0; m_taddr = 0; m_wrap = 0;
        end else if ((m_ph == M_IDLE || m_ph == M_DONE) && a) begin
            m_ph = M_PRE; m_nwr = 0; m_taddr = 0; m_trig = 0; m_done = 0; m_wrap = 0;
        end else if (w) begin
            addr = m_nwr % D;
            m_nwr++;
            if (m_nwr % D == 0) m_wrap = 1;
            if (m_ph == M_PRE) begin
`ifdef CWC_TRIG_HOLDOFF_EN
                hold_ok = (m_nwr - 1) >= (D - SL);
`else
                hold_ok = 1;
`endif
                if (th && hold_ok) begin
                    m_taddr = addr; m_trig = 1; m_left = SL - 1;
                    if (m_left == 0) begin m_ph = M_DONE; m_done = 1; end
                    else m_ph = M_POST;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin m_ph = M_DONE; m_done = 1; end
            end
        end
    endfunction

    // One clock: drive, compare at negedge, advance model at posedge
    task automatic step(input bit a, input bit ab, input bit se, input bit th);
        bit exp_en;
        bus.arm = a; bus.abort = ab; bus.sample_en = se; bus.trig_hit = th;
        @(negedge clk);
        exp_en = model_capturing() && se && !ab;
        chk("busy",      bus.busy,      model_capturing());
        chk("wt_ce",     bus.wt_ce,     model_capturing());
        chk("wt_en",     bus.wt_en,     exp_en);
        chk("wt_addr",   bus.wt_addr,   m_nwr % D);
        chk("trig_addr", bus.trig_addr, m_taddr);
        chk("triggered", bus.triggered, m_trig);
        chk("done",      bus.done,      m_done);
        chk("wrapped",   bus.wrapped,   m_wrap);
        last_wt_en = bus.wt_en;
        if (bus.wt_en === 1'b1) begin
            wr_pulses++;
            last_wr_addr = int'(bus.wt_addr);
        end
        @(posedge clk);
        model_step(a, ab, se, th);
        if (last_wt_en === 1'b1 && m_trig) post_writes++;
        #1;
    endtask

    task automatic clr_counts();
        wr_pulses = 0; last_wr_addr = -1; post_writes = 0;
    endtask

    initial begin
        bus.arm = 1'b0; bus.abort = 1'b0; bus.sample_en = 1'b0; bus.trig_hit = 1'b0;
        model_reset();
        clr_counts();

        // Reset state
        #2;
        chk("rst_busy",  bus.busy,  0);
        chk("rst_wt_ce", bus.wt_ce, 0);
        chk("rst_addr",  bus.wt_addr, 0);
        chk("rst_done",  bus.done,  0);
        @(negedge clk); jrstn = 1'b1;
        @(posedge clk); #1;

        // Idle without arm: no capture
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1);

        // Basic capture, trigger on 3rd PRE cycle
        clr_counts();
        step(1, 0, 0, 0);
        step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("s1_trig_addr", bus.trig_addr, 2);
        chk("s1_model_taddr", m_taddr, 2);
        chk("s1_last_addr", last_wr_addr, 6);
        chk("s1_pulses", wr_pulses, 7);
        chk("s1_done", bus.done, 1);
        chk("s1_wrapped", bus.wrapped, 0);

        // Trigger after 20 writes, wraps the RAM
        clr_counts();
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("s2_trig_addr", bus.trig_addr, 4);
        chk("s2_model_taddr", m_taddr, 4);
        chk("s2_wrapped", bus.wrapped, 1);
        chk("s2_last_addr", last_wr_addr, 8);
        chk("s2_pulses", wr_pulses, 25);

        // Gappy sample_en in POST, trig_hit without sample_en ignored in PRE
        clr_counts();
        step(1, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 1, 0); step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        for (int i = 0; i < 10; i++) step(0, 0, (i % 2) == 1, (i % 2) == 0);
        chk("s3_trig_addr", bus.trig_addr, 2);
        chk("s3_post_writes", post_writes, 5);
        chk("s3_last_addr", last_wr_addr, 6);
        chk("s3_done", bus.done, 1);

        // Abort with trig_hit and arm in POST
        clr_counts();
        step(1, 0, 0, 0);
        step(0, 0, 1, 0); step(0, 0, 1, 1); step(0, 0, 1, 0);
        step(1, 1, 1, 1);
        chk("s4_abort_wt_en", last_wt_en, 0);
        chk("s4_busy", bus.busy, 0);
        chk("s4_triggered", bus.triggered, 0);
        chk("s4_ptr_hold", bus.wt_addr, 3);
        step(0, 0, 1, 1);

        // Asynchronous reset mid-POST
        step(1, 0, 0, 0);
        step(0, 0, 1, 1); step(0, 0, 1, 0);
        bus.sample_en = 1'b1; bus.trig_hit = 1'b0; bus.arm = 1'b0; bus.abort = 1'b0;
        @(negedge clk); #2 jrstn = 1'b0; #1;
        chk("s5_wt_en", bus.wt_en, 0);
        chk("s5_wt_ce", bus.wt_ce, 0);
        chk("s5_busy", bus.busy, 0);
        chk("s5_trig", bus.triggered, 0);
        chk("s5_addr", bus.wt_addr, 0);
        chk("s5_taddr", bus.trig_addr, 0);
        chk("s5_done_wrap", {bus.done, bus.wrapped}, 0);
        model_reset();
        @(posedge clk); @(negedge clk);
        chk("s5_rst_wt_en", bus.wt_en, 0);
        jrstn = 1'b1;
        @(posedge clk); #1;
        clr_counts();
        for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
        chk("s5_no_writes", wr_pulses, 0);

        // trig_hit held from arm (holdoff behaviour)
        clr_counts();
        step(1, 0, 0, 1);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 1);
        step(0, 0, 0, 0);
`ifdef CWC_TRIG_HOLDOFF_EN
        chk("s6_trig_addr", bus.trig_addr, 11);
`else
        chk("s6_trig_addr", bus.trig_addr, 0);
`endif
        chk("s6_done", bus.done, 1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 16) == 0, ($urandom % 60) == 0,
                 ($urandom % 4) != 0, ($urandom % 7) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
